// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command byte transmitter on open-drain clk/data lines.
//
// Ports:
//   clk       in     system clock (single domain)
//   reset     in     synchronous, active-high
//   tx_data   in [8] command byte, captured when tx_start is accepted
//   tx_start  in     one-cycle request, accepted only while idle
//   tx_busy   out    high from the cycle after acceptance until the done/error pulse
//   tx_done   out    one-cycle pulse on device ACK
//   tx_error  out    one-cycle pulse on missing ACK (or watchdog expiry)
//   ps2_clk   inout  open-drain, driven 0 or z
//   ps2_data  inout  open-drain, driven 0 or z
//
// Optional feature: define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog of
// TIMEOUT_CYCLES cycles; without it the block waits indefinitely for the device.
module ps2_transmitter #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   inout  wire        ps2_clk,
   inout  wire        ps2_data
);
   localparam int CW = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);

   if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** 21) begin : g_bad_param
      $error("ps2_transmitter: INHIBIT_CYCLES must be >= 2 and TIMEOUT_CYCLES in 1..2^21-1");
   end

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

   state_t          state_q;
   logic [1:0]      clk_sync_q, dat_sync_q;
   logic            clk_hist_q;
   logic [9:0]      frame_q;
   logic [3:0]      bits_q;
   logic [CW-1:0]   inh_q;
   logic            clk_oe_q, dat_oe_q, busy_q, done_q, error_q;
   logic            fall;
`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [20:0] WD_LAST = 21'(TIMEOUT_CYCLES - 1);
   logic [20:0]     wd_q;
`endif

   assign fall     = clk_hist_q & ~clk_sync_q[1];
   assign ps2_clk  = clk_oe_q ? 1'b0 : 1'bz;
   assign ps2_data = dat_oe_q ? 1'b0 : 1'bz;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;
   assign tx_error = error_q;

   // Idle lines read high, so resetting the synchronizers to 1 avoids a false fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_hist_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         clk_hist_q <= clk_sync_q[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         bits_q   <= '0;
         inh_q    <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd_q     <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: if (tx_start) begin
               frame_q  <= {1'b1, ~^tx_data, tx_data};
               bits_q   <= '0;
               inh_q    <= '0;
               clk_oe_q <= 1'b1;
               busy_q   <= 1'b1;
               state_q  <= INHIBIT;
            end
            INHIBIT: begin
               inh_q <= inh_q + 1'b1;
               // Start bit goes low in the last inhibit cycle and stays low through REQ.
               if (inh_q == INH_DATA) dat_oe_q <= 1'b1;
               if (inh_q == INH_LAST) begin
                  clk_oe_q <= 1'b0;
                  state_q  <= REQ;
`ifdef PS2_TX_TIMEOUT_EN
                  wd_q     <= '0;
`endif
               end
            end
            // The first fall presents d0; the tenth presents the stop bit.
            REQ, SEND: if (fall) begin
               dat_oe_q <= ~frame_q[0];
               frame_q  <= frame_q >> 1;
               bits_q   <= bits_q + 1'b1;
               state_q  <= (bits_q == 4'd9) ? ACK : SEND;
            end
            ACK: if (fall) begin
               if (dat_sync_q[1]) begin
                  dat_oe_q <= 1'b0;
                  error_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  state_q  <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: if (clk_sync_q[1] & dat_sync_q[1]) begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Expiry overrides whatever the state logic decided this cycle.
         if (state_q inside {REQ, SEND, ACK, WAIT_IDLE}) begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               done_q   <= 1'b0;
               error_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: randomized self-checking bench with a behavioural PS/2 device model.
module tb_ps2_transmitter;
   localparam int INH = 100;
   localparam int TMO = 5000;
   localparam int H   = 40;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error;
   logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
   wire        ps2_clk, ps2_data;

   assign ps2_clk  = dev_clk_lo ? 1'b0 : 1'bz;
   assign ps2_data = dev_dat_lo ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   always #5 clk = ~clk;

   ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data)
   );

   int n_checks = 0, n_fail = 0;
   int done_cnt = 0, err_cnt = 0, wide_cnt = 0, busy_bad = 0;
   logic pd = 1'b0, pe = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt <= err_cnt + 1;
      if ((tx_done && pd) || (tx_error && pe)) wide_cnt <= wide_cnt + 1;
      if ((tx_done || tx_error) && tx_busy) busy_bad <= busy_bad + 1;
      pd <= tx_done;
      pe <= tx_error;
   end

   // Bits a device sees in order: start, d0..d7, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = ($countones(d) % 2) == 0;
      f[10]  = 1'b1;
      return f;
   endfunction

   task automatic dev_bit(output logic b);
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      @(negedge clk);
      b = ps2_data;
   endtask

   task automatic start_tx(input logic [7:0] d, input string tag);
      int lo, dlo;
      @(negedge clk);
      tx_data = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data = ~d;
      check({tag, " busy_on_accept"}, tx_busy, 1);
      check({tag, " clk_low_on_accept"}, ps2_clk, 0);
      lo = 0;
      dlo = 0;
      while (ps2_clk === 1'b0 && lo < INH + 10) begin
         lo++;
         if (ps2_data === 1'b0) dlo++;
         @(negedge clk);
      end
      check({tag, " inhibit_len"}, lo, INH);
      check({tag, " data_low_in_inhibit"}, dlo, 1);
   endtask

   task automatic send(input logic [7:0] d, input bit ack, input bit collide, input string tag);
      logic [10:0] got;
      int d0, e0, t;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(d, tag);
      got[0] = ps2_data;
      for (int k = 1; k <= 10; k++) begin
         dev_bit(got[k]);
         if (collide && k == 4) begin
            @(negedge clk);
            tx_data = 8'h00;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
         end
      end
      repeat (H) @(negedge clk);
      if (ack) dev_dat_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      repeat (H) @(negedge clk);
      dev_dat_lo = 1'b0;
      t = 0;
      while (done_cnt == d0 && err_cnt == e0 && t < 200) begin
         t++;
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check({tag, " frame"}, got, frame_of(d));
      check({tag, " done_count"}, done_cnt - d0, ack ? 1 : 0);
      check({tag, " error_count"}, err_cnt - e0, ack ? 0 : 1);
      check({tag, " busy_end"}, tx_busy, 0);
      check({tag, " clk_released"}, ps2_clk, 1);
      check({tag, " data_released"}, ps2_data, 1);
   endtask

   initial begin
      logic b;
      int d0, e0, c;
      repeat (3) @(negedge clk);
      check("reset busy", tx_busy, 0);
      check("reset done", tx_done, 0);
      check("reset error", tx_error, 0);
      check("reset clk", ps2_clk, 1);
      check("reset data", ps2_data, 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      send(8'hED, 1, 0, "send_ED");
      send(8'hF4, 1, 0, "send_F4");
      send(8'hFF, 1, 1, "collide_FF");
      send(8'h5A, 0, 0, "noack_5A");
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'($urandom_range(0, 3) != 0), 0, "random");

      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'h05, "rst_mid");
      for (int k = 1; k <= 3; k++) dev_bit(b);
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_mid host_drives_d3", ps2_data, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid busy", tx_busy, 0);
      check("rst_mid done", tx_done, 0);
      check("rst_mid error", tx_error, 0);
      check("rst_mid data_released", ps2_data, 1);
      dev_clk_lo = 1'b0;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_mid clk_released", ps2_clk, 1);
      check("rst_mid no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      send(8'hF4, 1, 0, "post_reset_F4");

`ifdef PS2_TX_TIMEOUT_EN
      e0 = err_cnt;
      start_tx(8'hA5, "timeout");
      c = 0;
      while (tx_error !== 1'b1 && c < TMO + 50) begin
         @(negedge clk);
         c++;
      end
      check("timeout cycles", c, TMO);
      repeat (5) @(negedge clk);
      check("timeout error_count", err_cnt - e0, 1);
      check("timeout clk_released", ps2_clk, 1);
      check("timeout data_released", ps2_data, 1);
`endif

      check("pulse_width", wide_cnt, 0);
      check("busy_at_pulse", busy_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
